rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares a 4-input mux datapath among four requesters. Each cycle it holds at most one registered one-hot grant and the matching 2-bit select. The selected requester's data is steered to a single output. The block sits in front of the shared mux/decoder resource and gives it the sequencing that the combinational path lacks: fair rotation, grant hold and an optional hold-time limit.

---
 rtl/rr_mux_arb_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/rr_mux_arbiter.sv | 142 ++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The hold-time limit is built only when RR_MUX_ARB_TIMEOUT_EN is defined.
package rr_mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot_dec(input logic [SEL_W-1:0] idx,
                                                    input logic             en);
        logic [N_REQ-1:0] v;
        v = '0;
        if (en) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner search: first set request at or after start, wrapping.
module rr_pick4
    import rr_mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] start_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        logic [SEL_W-1:0] j;
        logic             found;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = start_i + SEL_W'(k);
            if (!found && req_i[j]) begin
                idx_o = j;
                found = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and shared 4:1 data mux with registered one-hot grant.
// Optional hold-time limit: RR_MUX_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant outstanding, gnt=0, valid=0
// GRANT | gnt[sel] held until release (req drop or hold limit)
module rr_mux_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [3:0]       req,
    input  logic [4*W-1:0]   data,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [W-1:0]     f
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be >= 1");
    end

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] pick_start;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             release_c;

`ifdef RR_MUX_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Same picker serves both first grant (from ptr) and handover (from sel+1).
    assign pick_start = (state_q == GRANT) ? (sel_q + 2'd1) : ptr_q;

    rr_pick4 u_pick (
        .req_i   (req),
        .start_i (pick_start),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

`ifdef RR_MUX_ARB_TIMEOUT_EN
    assign release_c = !req[sel_q] || (hold_cnt_q == HOLD_LAST);
`else
    assign release_c = !req[sel_q];
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef RR_MUX_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot_dec(pick_idx, 1'b1);
                    valid_d = 1'b1;
`ifdef RR_MUX_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = sel_q + 2'd1;
                    if (pick_any) begin
                        sel_d = pick_idx;
                        gnt_d = onehot_dec(pick_idx, 1'b1);
`ifdef RR_MUX_ARB_TIMEOUT_EN
                        hold_cnt_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else begin
`ifdef RR_MUX_ARB_TIMEOUT_EN
                    if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_MUX_ARB_TIMEOUT_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) hold_cnt_q <= '0;
        else         hold_cnt_q <= hold_cnt_d;
    end
`endif

    // Output mux is driven only from registers plus data, never from req.
    always_comb begin
        f = '0;
        if (valid_q) f = data[sel_q*W +: W];
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (default and timeout builds).
module tb_rr_mux_arbiter;

    localparam int W        = 8;
    localparam int MAX_HOLD = 2;

    logic           Clock;
    logic           Resetn;
    logic [3:0]     req;
    logic [4*W-1:0] data;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic           valid;
    logic [W-1:0]   f;

    int n_checks;
    int n_fail;

    rr_mux_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .req    (req),
        .data   (data),
        .gnt    (gnt),
        .sel    (sel),
        .valid  (valid),
        .f      (f)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        req    = 4'b0000;
        step();
        Resetn = 1'b1;
    endtask

`ifdef RR_MUX_ARB_TIMEOUT_EN
    logic [3:0] rot_exp [9];
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Resetn   = 1'b0;
        req      = 4'b0000;
        data     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        #3;
        check_eq("rst_gnt",   32'(gnt),   32'h0);
        check_eq("rst_sel",   32'(sel),   32'h0);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_f",     32'(f),     32'h0);

        @(negedge Clock);
        Resetn = 1'b1;
        req    = 4'b0001;
        step();
        check_eq("g0_gnt",   32'(gnt),   32'h1);
        check_eq("g0_sel",   32'(sel),   32'h0);
        check_eq("g0_valid", 32'(valid), 32'h1);
        check_eq("g0_f",     32'(f),     32'hA0);

        data[7:0] = 8'h55;
        #1;
        check_eq("f_comb", 32'(f), 32'h55);
        data[7:0] = 8'hA0;

        // holder 0 drops while 2 raises on the same edge
        req = 4'b0100;
        step();
        check_eq("ho_gnt", 32'(gnt), 32'h4);
        check_eq("ho_sel", 32'(sel), 32'h2);
        check_eq("ho_f",   32'(f),   32'hC2);

        req = 4'b0000;
        step();
        check_eq("idle_gnt",   32'(gnt),   32'h0);
        check_eq("idle_valid", 32'(valid), 32'h0);
        check_eq("idle_sel",   32'(sel),   32'h2);
        check_eq("idle_f",     32'(f),     32'h0);

        // ptr is now 3, so all-request restart goes to index 3
        req = 4'b1111;
        step();
        check_eq("rs_gnt", 32'(gnt), 32'h8);
        check_eq("rs_sel", 32'(sel), 32'h3);
        check_eq("rs_f",   32'(f),   32'hD3);

        req = 4'b0011;
        step();
        check_eq("ho2_gnt", 32'(gnt), 32'h1);

        req = 4'b0100;
        step();
        check_eq("pre_rst_gnt", 32'(gnt), 32'h4);

        Resetn = 1'b0;
        #1;
        check_eq("mrst_gnt",   32'(gnt),   32'h0);
        check_eq("mrst_sel",   32'(sel),   32'h0);
        check_eq("mrst_valid", 32'(valid), 32'h0);
        check_eq("mrst_f",     32'(f),     32'h0);
        req = 4'b1010;
        step();
        check_eq("in_rst_gnt", 32'(gnt), 32'h0);
        Resetn = 1'b1;
        step();
        check_eq("post_rst_gnt", 32'(gnt), 32'h2);
        check_eq("post_rst_f",   32'(f),   32'hB1);

`ifdef RR_MUX_ARB_TIMEOUT_EN
        // MAX_HOLD=2: holder 1 times out and 3 takes over
        step();
        check_eq("to_hold_gnt", 32'(gnt), 32'h2);
        step();
        check_eq("to_rel_gnt", 32'(gnt), 32'h8);

        do_reset();
        rot_exp = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
        req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            step();
            check_eq($sformatf("rot%0d", i), 32'(gnt), 32'(rot_exp[i]));
        end

        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq($sformatf("self_gnt%0d", i), 32'(gnt), 32'h8);
            check_eq($sformatf("self_hc%0d", i), 32'(dut.hold_cnt_q), 32'(i % 2));
        end
`else
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq($sformatf("hold%0d", i), 32'(gnt), 32'h2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
